dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters and decodes each access to the data bank or the stack bank.
- Requester m0 is the CPU data port. Requester m1 is a debug/preload port used to load or inspect memory around CPU execution.
- Replaces the current wiring, where one write enable drives both banks. Each bank now gets its own enable, and out-of-range or misaligned accesses are flagged.

Parameters:
- DATA_BASE, 32'h10010000, byte address of data bank word 0
- DATA_WORDS, 36, data bank depth in words
- STACK_TOP, 32'h7fffeffc, stack bank base is STACK_TOP - STACK_WORDS*4
- STACK_WORDS, 36, stack bank depth in words
- MAX_HOLD, 4, maximum consecutive granted cycles while the other requester waits (must be >= 1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  CPU access request
- m0_wen  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_gnt  out  1  access performed this cycle
- m0_rdata  out  32  read data, valid when m0_gnt=1
- m0_stall  out  1  m0_req & ~m0_gnt
- m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rdata  as m0, for the debug port
- mem_addr  out  32  shared address to both banks
- mem_wdata  out  32  shared write data
- data_wen  out  1  data bank write enable
- stack_wen  out  1  stack bank write enable
- data_rdata  in  32  data bank read data (combinational read)
- stack_rdata  in  32  stack bank read data (combinational read)
- err_valid  out  1  one-cycle pulse on a granted access that decodes to no bank
- err_addr  out  32  address of the most recent error, held until the next error

Behaviour:
- Reset values: state=IDLE, rr=m0, hold_cnt=0. All gnt, wen and err_valid = 0. mem_addr, mem_wdata, err_addr and all rdata = 0.
- While rst=1, all gnt and wen outputs are forced to 0 combinationally. Reset mid-transfer therefore drops the grant in the same cycle, and no write reaches memory.
- States are IDLE, OWN0 and OWN1, all registered. mi_gnt = (state==OWNi) & mi_req.
- IDLE, one requester active: move to its OWN state. The first grant comes one cycle after req rises.
- IDLE, both active: grant the requester indicated by rr, which points at the requester not served last.
- OWNi, mi_req held, other requester idle: stay. hold_cnt stays 0.
- OWNi, mi_req held, other requester waiting: hold_cnt increments each granted cycle. When hold_cnt reaches MAX_HOLD-1, move directly to OWNother next cycle with no IDLE bubble. hold_cnt clears on every state change.
- OWNi, mi_req drops: move to OWNother if the other is requesting, else to IDLE. rr is set to the other requester.
- Dropping req while owning a grant is legal; the requester simply loses ownership.
- Address decode, applied to the owner's address:
  - DATA hit: DATA_BASE <= a < DATA_BASE + 4*DATA_WORDS
  - STACK hit: STACK_TOP - 4*STACK_WORDS <= a < STACK_TOP
  - Both comparisons are done at 33-bit width to avoid wrap-around.
  - a[1:0] != 0, or neither range matches, is an error.
- Granted write: the matching bank's wen = 1 and the other bank's wen = 0. On an error, neither wen is asserted.
- Granted read: owner rdata = data_rdata or stack_rdata by decode, and 0 on an error. rdata is combinational, same cycle as gnt.
- On an error: err_valid = 1 in the next cycle and err_addr is registered.
- Non-granted requester's rdata = 0. With no grant, mem_addr = 0 and mem_wdata = 0.
- Requester inputs are sampled only while granted and must stay stable while req=1.

Decomposition:
- Shared package: the state enum (IDLE/OWN0/OWN1), the requester-index constants, and the default bank base/depth constants also used by the testbench.
- One sub-module, dmem_region_decode: combinational, takes an address and returns hit_data, hit_stack and err.
- Arbitration FSM, hold counter and muxing stay in dmem_arbiter.

Test Plan:
1. m0 alone writes 32'hDEADBEEF to 0x10010008 -> m0_gnt one cycle after req; data_wen=1, stack_wen=0, mem_addr=0x10010008; a subsequent read returns 32'hDEADBEEF.
2. m1 writes 0x1234 to 0x7fffeff8 -> stack_wen=1, data_wen=0; 0x7fffeffc, the first word past the stack bank, gives err_valid pulse and err_addr=0x7fffeffc with no wen.
3. m0 and m1 request together from reset -> m0 is granted first. With both held: m0 gets exactly 4 cycles, then m1 gets 4, alternating, with no idle cycle between owners.
4. m0 holds req with m1 idle for 20 cycles -> m0_gnt high for all 20; m1 rises -> m1 granted after at most 4 more m0 cycles.
5. Misaligned 0x10010002 and out-of-range 0x10010090 -> err_valid pulse for each, err_addr updated each time, rdata=0, no write.
6. rst asserted in the middle of an m1 burst -> m1_gnt and all wen = 0 in that cycle; state IDLE after the edge; after release, a new m0 request is granted first.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default memory-map constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  localparam logic ReqM0 = 1'b0;
  localparam logic ReqM1 = 1'b1;

  localparam logic [31:0] DefDataBase   = 32'h1001_0000;
  localparam int unsigned DefDataWords  = 36;
  localparam logic [31:0] DefStackTop   = 32'h7fff_effc;
  localparam int unsigned DefStackWords = 36;
  localparam int unsigned DefMaxHold    = 4;

  // Byte span of a bank, widened so range bounds never wrap.
  function automatic logic [32:0] word_span(input int unsigned words);
    return 33'(words) << 2;
  endfunction

endpackage

// File: rtl/dmem_region_decode.sv
// Maps a byte address onto the data or stack bank; anything else is an error.
module dmem_region_decode
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DefDataBase,
  parameter int unsigned DATA_WORDS  = DefDataWords,
  parameter logic [31:0] STACK_TOP   = DefStackTop,
  parameter int unsigned STACK_WORDS = DefStackWords
) (
  input  logic [31:0] addr,
  output logic        hit_data,
  output logic        hit_stack,
  output logic        err
);

  localparam logic [32:0] DataLo  = {1'b0, DATA_BASE};
  localparam logic [32:0] DataHi  = DataLo + word_span(DATA_WORDS);
  localparam logic [32:0] StackHi = {1'b0, STACK_TOP};
  localparam logic [32:0] StackLo = StackHi - word_span(STACK_WORDS);

  logic [32:0] addr_w;
  logic        aligned;
  logic        in_data;
  logic        in_stack;

  always_comb begin
    addr_w    = {1'b0, addr};
    aligned   = (addr[1:0] == 2'b00);
    in_data   = (addr_w >= DataLo) && (addr_w < DataHi);
    in_stack  = (addr_w >= StackLo) && (addr_w < StackHi);
    hit_data  = aligned & in_data;
    // Data bank wins should the two windows ever be configured to overlap.
    hit_stack = aligned & in_stack & ~in_data;
    err       = ~(hit_data | hit_stack);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared data-memory port with per-bank write enables.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DefDataBase,
  parameter int unsigned DATA_WORDS  = DefDataWords,
  parameter logic [31:0] STACK_TOP   = DefStackTop,
  parameter int unsigned STACK_WORDS = DefStackWords,
  parameter int unsigned MAX_HOLD    = DefMaxHold
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        data_wen,
  output logic        stack_wen,
  input  logic [31:0] data_rdata,
  input  logic [31:0] stack_rdata,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               err_valid_q, err_valid_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic               own_is1;
  logic               own_req;
  logic               oth_req;
  logic               any_gnt;
  logic               own_wen;
  logic [31:0]        own_addr;
  logic [31:0]        own_wdata;
  logic [31:0]        rd_mux;
  logic               hit_data;
  logic               hit_stack;
  logic               dec_err;

  dmem_region_decode #(
    .DATA_BASE  (DATA_BASE),
    .DATA_WORDS (DATA_WORDS),
    .STACK_TOP  (STACK_TOP),
    .STACK_WORDS(STACK_WORDS)
  ) u_decode (
    .addr     (mem_addr),
    .hit_data (hit_data),
    .hit_stack(hit_stack),
    .err      (dec_err)
  );

  // Datapath: grants are masked by rst so a reset mid-burst never writes.
  always_comb begin
    own_is1   = (state_q == StOwn1);
    m0_gnt    = ~rst & (state_q == StOwn0) & m0_req;
    m1_gnt    = ~rst & (state_q == StOwn1) & m1_req;
    any_gnt   = m0_gnt | m1_gnt;
    m0_stall  = m0_req & ~m0_gnt;
    own_addr  = own_is1 ? m1_addr : m0_addr;
    own_wdata = own_is1 ? m1_wdata : m0_wdata;
    own_wen   = own_is1 ? m1_wen : m0_wen;
    mem_addr  = any_gnt ? own_addr : 32'h0;
    mem_wdata = any_gnt ? own_wdata : 32'h0;
    data_wen  = any_gnt & own_wen & hit_data;
    stack_wen = any_gnt & own_wen & hit_stack;
    rd_mux    = hit_data ? data_rdata : (hit_stack ? stack_rdata : 32'h0);
    m0_rdata  = m0_gnt ? rd_mux : 32'h0;
    m1_rdata  = m1_gnt ? rd_mux : 32'h0;
    err_valid = err_valid_q;
    err_addr  = err_addr_q;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    err_valid_d = any_gnt & dec_err;
    err_addr_d  = (any_gnt & dec_err) ? mem_addr : err_addr_q;
    own_req     = own_is1 ? m1_req : m0_req;
    oth_req     = own_is1 ? m0_req : m1_req;

    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          state_d = (rr_q == ReqM0) ? StOwn0 : StOwn1;
        end else if (m0_req) begin
          state_d = StOwn0;
        end else if (m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (!own_req || (oth_req && hold_q == HoldLast)) begin
          // Hand over directly when the other side waits, else fall back to idle.
          state_d = oth_req ? (own_is1 ? StOwn0 : StOwn1) : StIdle;
          rr_d    = own_is1 ? ReqM0 : ReqM1;
          hold_d  = '0;
        end else if (oth_req) begin
          hold_d = hold_q + HoldW'(1);
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= ReqM0;
      hold_q      <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with small behavioural data and stack banks.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_stall, m1_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, data_rdata, stack_rdata, err_addr;
  logic        data_wen, stack_wen, err_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_wen     (m0_wen),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rdata   (m0_rdata),
    .m0_stall   (m0_stall),
    .m1_req     (m1_req),
    .m1_wen     (m1_wen),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rdata   (m1_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .data_wen   (data_wen),
    .stack_wen  (stack_wen),
    .data_rdata (data_rdata),
    .stack_rdata(stack_rdata),
    .err_valid  (err_valid),
    .err_addr   (err_addr)
  );

  // Bank models, indexed by the bench's own view of the memory map.
  localparam logic [31:0] StackBase = 32'h7fff_ef6c;
  logic [31:0] data_mem  [64];
  logic [31:0] stack_mem [64];
  logic [31:0] d_off, s_off;
  logic        d_in, s_in;

  assign d_off       = mem_addr - DefDataBase;
  assign s_off       = mem_addr - StackBase;
  assign d_in        = d_off < 32'd144;
  assign s_in        = s_off < 32'd144;
  assign data_rdata  = d_in ? data_mem[d_off[7:2]] : 32'h0;
  assign stack_rdata = s_in ? stack_mem[s_off[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (data_wen && d_in) data_mem[d_off[7:2]] <= mem_wdata;
    if (stack_wen && s_in) stack_mem[s_off[7:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // m0 access that decodes to no bank: granted, no wen, zero rdata, error pulse next cycle.
  task automatic err_access(input string tag, input logic [31:0] addr, input logic wen);
    m0_req = 1'b1; m0_wen = wen; m0_addr = addr; m0_wdata = 32'hBAD0_BAD0;
    nxt();
    @(negedge clk);
    check_eq({tag, "_gnt"}, 32'(m0_gnt), 32'd1);
    check_eq({tag, "_rdata"}, m0_rdata, 32'h0);
    check_eq({tag, "_wen"}, {30'd0, data_wen, stack_wen}, 32'd0);
    check_eq({tag, "_errv_early"}, 32'(err_valid), 32'd0);
    nxt();
    m0_req = 1'b0;
    @(negedge clk);
    check_eq({tag, "_errv"}, 32'(err_valid), 32'd1);
    check_eq({tag, "_erra"}, err_addr, addr);
    nxt();
    @(negedge clk);
    check_eq({tag, "_errv_pulse"}, 32'(err_valid), 32'd0);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    int got;
    int cnt;
    logic [1:0] exp_g;

    for (int i = 0; i < 64; i++) begin
      data_mem[i]  = 32'h0;
      stack_mem[i] = 32'h0;
    end
    rst = 1'b1;
    m0_req = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
    nxt();
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ctl", {27'd0, m0_gnt, m1_gnt, data_wen, stack_wen, err_valid}, 32'd0);
    check_eq("reset_addr", mem_addr, 32'h0);
    check_eq("reset_erra", err_addr, 32'h0);
    check_eq("reset_rdata", m0_rdata | m1_rdata, 32'h0);
    nxt();

    // 1: m0 write then read of the data bank.
    m0_req = 1; m0_wen = 1; m0_addr = 32'h1001_0008; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("t1_stall", {31'd0, m0_stall}, 32'd1);
    nxt();
    @(negedge clk);
    check_eq("t1_gnt", 32'(m0_gnt), 32'd1);
    check_eq("t1_wen", {30'd0, data_wen, stack_wen}, 32'd2);
    check_eq("t1_addr", mem_addr, 32'h1001_0008);
    check_eq("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    nxt();
    m0_req = 0;
    nxt();
    m0_req = 1; m0_wen = 0;
    nxt();
    @(negedge clk);
    check_eq("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    check_eq("t1_m1_rdata", m1_rdata, 32'h0);
    nxt();
    m0_req = 0;
    nxt();

    // 2: m1 stack write, then the first word past the stack bank.
    m1_req = 1; m1_wen = 1; m1_addr = 32'h7fff_eff8; m1_wdata = 32'h1234;
    nxt();
    @(negedge clk);
    check_eq("t2_gnt", 32'(m1_gnt), 32'd1);
    check_eq("t2_wen", {30'd0, data_wen, stack_wen}, 32'd1);
    nxt();
    m1_req = 0;
    nxt();
    m1_req = 1; m1_addr = 32'h7fff_effc;
    nxt();
    @(negedge clk);
    check_eq("t2_err_gnt", 32'(m1_gnt), 32'd1);
    check_eq("t2_err_wen", {30'd0, data_wen, stack_wen}, 32'd0);
    nxt();
    m1_req = 0;
    @(negedge clk);
    check_eq("t2_errv", 32'(err_valid), 32'd1);
    check_eq("t2_erra", err_addr, 32'h7fff_effc);
    nxt();
    @(negedge clk);
    check_eq("t2_errv_pulse", 32'(err_valid), 32'd0);
    nxt();

    // 3: simultaneous requests from reset alternate in blocks of four.
    rst = 1;
    nxt();
    rst = 0;
    @(negedge clk);
    check_eq("t3_erra_reset", err_addr, 32'h0);
    nxt();
    m0_req = 1; m0_wen = 0; m0_addr = 32'h1001_0008;
    m1_req = 1; m1_wen = 0; m1_addr = 32'h7fff_eff8;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      exp_g = (i == 0) ? 2'b00 : ((((i - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01);
      check_eq($sformatf("t3_gnt_c%0d", i), {30'd0, m0_gnt, m1_gnt}, {30'd0, exp_g});
      if (i == 1) check_eq("t3_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      if (i == 5) check_eq("t3_m1_rdata", m1_rdata, 32'h1234);
      nxt();
    end
    m0_req = 0; m1_req = 0;
    nxt();
    nxt();

    // 4: m0 keeps ownership while m1 is idle, yields within MAX_HOLD once m1 asks.
    m0_req = 1; m0_addr = 32'h1001_0000;
    nxt();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_gnt) cnt++;
      nxt();
    end
    check_eq("t4_m0_hold", 32'(cnt), 32'd20);
    m1_req = 1; m1_addr = 32'h1001_0004;
    waited = 0;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(negedge clk);
      if (m1_gnt) got = 1;
      else begin
        if (m0_gnt) waited++;
        nxt();
      end
    end
    check_eq("t4_m1_gnt", 32'(got), 32'd1);
    check_eq("t4_m0_cycles", 32'(waited), 32'd4);
    nxt();
    m0_req = 0; m1_req = 0;
    nxt();
    nxt();

    // 5: misaligned and out-of-range accesses.
    err_access("t5_misalign", 32'h1001_0002, 1'b0);
    err_access("t5_range", 32'h1001_0090, 1'b1);
    check_eq("t5_no_write", data_mem[0], 32'h0);

    // 6: reset in the middle of an m1 burst.
    m1_req = 1; m1_wen = 1; m1_addr = 32'h1001_0000; m1_wdata = 32'h55;
    nxt();
    @(negedge clk);
    check_eq("t6_gnt", 32'(m1_gnt), 32'd1);
    nxt();
    m1_wdata = 32'h55;
    rst = 1;
    @(negedge clk);
    check_eq("t6_rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    check_eq("t6_rst_wen", {30'd0, data_wen, stack_wen}, 32'd0);
    nxt();
    rst = 0;
    m0_req = 1; m0_wen = 0; m0_addr = 32'h1001_0000;
    @(negedge clk);
    check_eq("t6_idle", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    nxt();
    @(negedge clk);
    check_eq("t6_m0_first", {30'd0, m0_gnt, m1_gnt}, 32'd2);
    check_eq("t6_rdata", m0_rdata, 32'h55);
    nxt();
    m0_req = 0; m1_req = 0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
